// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone program-memory arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef logic master_idx_t;

  localparam master_idx_t M0 = 1'b0;
  localparam master_idx_t M1 = 1'b1;

  function automatic logic [1:0] grant_decode(input arb_state_t s);
    case (s)
      GNT0:    return 2'b01;
      GNT1:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_bus.sv
// Minimal classic Wishbone bus bundle used between masters, arbiter and slave.
interface wb_bus;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        we;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (output addr, wdata, we, stb, input rdata, ack, err);
  modport slave  (input addr, wdata, we, stb, output rdata, ack, err);
endinterface

// File: rtl/wb_arb_timeout.sv
// Grant watchdog: counts granted cycles without termination and flags expiry.
module wb_arb_timeout #(
  parameter int TimeoutCycles = 16,
  parameter int CntWidth      = 8
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic active,
  input  logic stb,
  input  logic term,
  output logic expired
);

  logic [CntWidth-1:0] cnt;

  // The mandatory IDLE cycle between grants clears the count, so every grant starts at zero.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      cnt <= '0;
    end else begin
      cnt <= active ? cnt + CntWidth'(1) : '0;
    end
  end

  assign expired = active && stb && !term && (cnt == CntWidth'(TimeoutCycles - 1));

endmodule

// File: rtl/wb_memory_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the program memory.
// Optional grant watchdog enabled with `define WB_ARB_TIMEOUT_EN.
module wb_memory_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TimeoutCycles = 16,
  parameter int CntWidth      = 8
) (
  input  logic       clk_in,
  input  logic       reset_in,
  wb_bus.slave       m0_bus,
  wb_bus.slave       m1_bus,
  wb_bus.master      s_bus,
  output logic [1:0] grant_out,
  output logic [1:0] state_dbg
);

  // Handshake: stb is the request and stays high with stable addr/we/wdata
  // until the cycle in which ack or err (single-cycle completion) is seen.

  arb_state_t  state;
  arb_state_t  next_state;
  master_idx_t last_grant;
  logic        gnt_active;
  logic        gnt_stb;
  logic        term;
  logic        timeout_err;

  if (2 ** CntWidth <= TimeoutCycles) begin : g_cfg_check
    $error("wb_memory_arbiter: CntWidth too small for TimeoutCycles");
  end

  assign gnt_active = (state != IDLE);
  assign term       = s_bus.ack | s_bus.err;
  assign state_dbg  = state;

  always_comb begin
    gnt_stb = 1'b0;
    case (state)
      GNT0:    gnt_stb = m0_bus.stb;
      GNT1:    gnt_stb = m1_bus.stb;
      default: gnt_stb = 1'b0;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_timeout #(
    .TimeoutCycles(TimeoutCycles),
    .CntWidth     (CntWidth)
  ) u_timeout (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .active  (gnt_active),
    .stb     (gnt_stb),
    .term    (term),
    .expired (timeout_err)
  );
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state      <= IDLE;
      last_grant <= M1;
      grant_out  <= 2'b00;
    end else begin
      state     <= next_state;
      grant_out <= grant_decode(next_state);
      if (gnt_active && next_state == IDLE) begin
        last_grant <= (state == GNT1) ? M1 : M0;
      end
    end
  end

  // Requests seen during a terminating cycle are only arbitrated in the following IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (m0_bus.stb && m1_bus.stb) begin
          next_state = (last_grant == M1) ? GNT0 : GNT1;
        end else if (m0_bus.stb) begin
          next_state = GNT0;
        end else if (m1_bus.stb) begin
          next_state = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (term || timeout_err || !gnt_stb) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    s_bus.addr   = '0;
    s_bus.wdata  = '0;
    s_bus.we     = 1'b0;
    s_bus.stb    = 1'b0;
    m0_bus.ack   = 1'b0;
    m0_bus.err   = 1'b0;
    m1_bus.ack   = 1'b0;
    m1_bus.err   = 1'b0;
    m0_bus.rdata = s_bus.rdata;
    m1_bus.rdata = s_bus.rdata;
    case (state)
      GNT0: begin
        s_bus.addr  = m0_bus.addr;
        s_bus.wdata = m0_bus.wdata;
        s_bus.we    = m0_bus.we;
        s_bus.stb   = m0_bus.stb & ~timeout_err;
        m0_bus.ack  = s_bus.ack;
        m0_bus.err  = s_bus.err | timeout_err;
      end
      GNT1: begin
        s_bus.addr  = m1_bus.addr;
        s_bus.wdata = m1_bus.wdata;
        s_bus.we    = m1_bus.we;
        s_bus.stb   = m1_bus.stb & ~timeout_err;
        m1_bus.ack  = s_bus.ack;
        m1_bus.err  = s_bus.err | timeout_err;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_memory_arbiter.sv
// Scoreboard bench for wb_memory_arbiter with a read-only program memory slave model.
module tb_wb_memory_arbiter;

  logic       clk_in;
  logic       reset_in;
  logic [1:0] grant_out;
  logic [1:0] state_dbg;
  logic       ack_en;

  wb_bus m0_if();
  wb_bus m1_if();
  wb_bus s_if();

  int vectors;
  int miscompares;
  int ack_cnt0;
  int ack_cnt1;

  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic [1:0]  exp_gq[$];
  logic [1:0]  prev_grant;

  wb_memory_arbiter #(.TimeoutCycles(4), .CntWidth(8)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .m0_bus   (m0_if),
    .m1_bus   (m1_if),
    .s_bus    (s_if),
    .grant_out(grant_out),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // program memory: word i reads as C0DE_0000 + i; writes and misaligned accesses return err
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      s_if.ack   <= 1'b0;
      s_if.err   <= 1'b0;
      s_if.rdata <= '0;
    end else begin
      s_if.ack <= 1'b0;
      s_if.err <= 1'b0;
      if (s_if.stb && !s_if.ack && !s_if.err && ack_en) begin
        if (s_if.we || s_if.addr[1:0] != 2'b00) begin
          s_if.err   <= 1'b1;
          s_if.rdata <= '0;
        end else begin
          s_if.ack   <= 1'b1;
          s_if.rdata <= 32'hC0DE_0000 | {16'h0, s_if.addr[17:2]};
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input int idx, input logic [31:0] addr, input logic we, input logic [31:0] wdata);
    #1;
    if (idx == 0) begin
      m0_if.addr = addr; m0_if.we = we; m0_if.wdata = wdata; m0_if.stb = 1'b1;
    end else begin
      m1_if.addr = addr; m1_if.we = we; m1_if.wdata = wdata; m1_if.stb = 1'b1;
    end
  endtask

  task automatic release_m(input int idx);
    if (idx == 0) m0_if.stb = 1'b0;
    else          m1_if.stb = 1'b0;
  endtask

  task automatic wait_term(input int idx, input bit hold);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 60) begin
      @(negedge clk_in);
      n++;
      done = (idx == 0) ? (m0_if.ack | m0_if.err) : (m1_if.ack | m1_if.err);
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_term m%0d: got no ack/err expected one within 60 cycles", idx);
    end
    #1;
    if (!hold || !done) release_m(idx);
  endtask

  task automatic xfer(input int idx, input logic [31:0] addr, input logic we,
                      input logic exp_err, input logic [31:0] exp_rdata, input bit hold);
    if (idx == 0) exp_q0.push_back({exp_err, exp_rdata});
    else          exp_q1.push_back({exp_err, exp_rdata});
    drive(idx, addr, we, 32'hDEAD_0000 | addr);
    wait_term(idx, hold);
  endtask

  // scoreboard monitor
  always @(negedge clk_in) begin
    logic [32:0] e;
    if (reset_in) begin
      if (m0_if.ack || m0_if.err) begin
        chk("m0_owner", {62'h0, grant_out}, 64'h1);
        if (m0_if.ack) ack_cnt0++;
        if (exp_q0.size() == 0) begin
          chk("m0_unexpected_term", 64'h1, 64'h0);
        end else begin
          e = exp_q0.pop_front();
          chk("m0_err", {63'h0, m0_if.err}, {63'h0, e[32]});
          if (!e[32]) chk("m0_rdata", {32'h0, m0_if.rdata}, {32'h0, e[31:0]});
        end
      end
      if (m1_if.ack || m1_if.err) begin
        chk("m1_owner", {62'h0, grant_out}, 64'h2);
        if (m1_if.ack) ack_cnt1++;
        if (exp_q1.size() == 0) begin
          chk("m1_unexpected_term", 64'h1, 64'h0);
        end else begin
          e = exp_q1.pop_front();
          chk("m1_err", {63'h0, m1_if.err}, {63'h0, e[32]});
          if (!e[32]) chk("m1_rdata", {32'h0, m1_if.rdata}, {32'h0, e[31:0]});
        end
      end
      if (grant_out != prev_grant && grant_out != 2'b00) begin
        chk("grant_idle_gap", {62'h0, prev_grant}, 64'h0);
        if (exp_gq.size() == 0) chk("grant_unexpected", {62'h0, grant_out}, 64'h0);
        else                    chk("grant_order", {62'h0, grant_out}, {62'h0, exp_gq.pop_front()});
      end
    end
    prev_grant = grant_out;
  end

  initial begin
    int a0;
    int a1;
    vectors = 0; miscompares = 0; ack_cnt0 = 0; ack_cnt1 = 0;
    prev_grant = 2'b00;
    ack_en = 1'b1;
    reset_in = 1'b0;
    m0_if.addr = '0; m0_if.wdata = '0; m0_if.we = 1'b0; m0_if.stb = 1'b0;
    m1_if.addr = '0; m1_if.wdata = '0; m1_if.we = 1'b0; m1_if.stb = 1'b0;

    // reset state
    repeat (3) @(negedge clk_in);
    chk("rst_grant", {62'h0, grant_out}, 64'h0);
    chk("rst_state", {62'h0, state_dbg}, 64'h0);
    chk("rst_s_stb", {63'h0, s_if.stb}, 64'h0);
    chk("rst_m0_ackerr", {62'h0, m0_if.ack, m0_if.err}, 64'h0);
    chk("rst_m1_ackerr", {62'h0, m1_if.ack, m1_if.err}, 64'h0);
    #1 reset_in = 1'b1;

    // both request right after reset: m0 first, then m1
    @(negedge clk_in);
    exp_gq.push_back(2'b01); exp_gq.push_back(2'b10);
    fork
      xfer(0, 32'h0000_0000, 1'b0, 1'b0, 32'hC0DE_0000, 1'b0);
      xfer(1, 32'h0000_0008, 1'b0, 1'b0, 32'hC0DE_0002, 1'b0);
    join

    // continuous contention: strict alternation, 3 acks each
    a0 = ack_cnt0; a1 = ack_cnt1;
    for (int i = 0; i < 3; i++) begin
      exp_gq.push_back(2'b01); exp_gq.push_back(2'b10);
    end
    @(negedge clk_in);
    fork
      for (int i = 0; i < 3; i++)
        xfer(0, 32'h0000_0100 + 32'(4 * i), 1'b0, 1'b0, 32'hC0DE_0040 + 32'(i), i < 2);
      for (int j = 0; j < 3; j++)
        xfer(1, 32'h0000_0200 + 32'(4 * j), 1'b0, 1'b0, 32'hC0DE_0080 + 32'(j), j < 2);
    join
    chk("m0_ack_count", 64'(ack_cnt0 - a0), 64'd3);
    chk("m1_ack_count", 64'(ack_cnt1 - a1), 64'd3);

    // single m0 read of 0x10 with cycle-exact timing
    @(negedge clk_in);
    exp_gq.push_back(2'b01);
    exp_q0.push_back({1'b0, 32'hC0DE_0004});
    drive(0, 32'h0000_0010, 1'b0, 32'h0);
    @(negedge clk_in);
    chk("t1_grant", {62'h0, grant_out}, 64'h1);
    chk("t1_early_ack", {63'h0, m0_if.ack}, 64'h0);
    @(negedge clk_in);
    chk("t1_ack", {63'h0, m0_if.ack}, 64'h1);
    chk("t1_rdata", {32'h0, m0_if.rdata}, 64'hC0DE_0004);
    #1 release_m(0);
    @(negedge clk_in);
    chk("t1_idle", {62'h0, grant_out}, 64'h0);

    // m1 write gets slave err; then round-robin puts m0 first
    @(negedge clk_in);
    exp_gq.push_back(2'b10);
    xfer(1, 32'h0000_0000, 1'b1, 1'b1, 32'h0, 1'b0);
    exp_gq.push_back(2'b01); exp_gq.push_back(2'b10);
    fork
      xfer(0, 32'h0000_0014, 1'b0, 1'b0, 32'hC0DE_0005, 1'b0);
      xfer(1, 32'h0000_0018, 1'b0, 1'b0, 32'hC0DE_0006, 1'b0);
    join

    // reset in GNT0 with stb held, ack due that cycle
    @(negedge clk_in);
    exp_gq.push_back(2'b01);
    drive(0, 32'h0000_0020, 1'b0, 32'h0);
    @(negedge clk_in);
    @(posedge clk_in);
    #1 reset_in = 1'b0;
    #1;
    chk("rst_mid_s_stb", {63'h0, s_if.stb}, 64'h0);
    chk("rst_mid_grant", {62'h0, grant_out}, 64'h0);
    chk("rst_mid_m0_ack", {63'h0, m0_if.ack}, 64'h0);
    repeat (2) @(negedge clk_in);
    exp_gq.push_back(2'b01);
    exp_q0.push_back({1'b0, 32'hC0DE_0008});
    #1 reset_in = 1'b1;
    @(negedge clk_in);
    chk("rst_rel_grant", {62'h0, grant_out}, 64'h1);
    wait_term(0, 1'b0);

`ifdef WB_ARB_TIMEOUT_EN
    // slave silent: m0 times out on 4th GNT0 cycle, pending m1 is served next
    @(negedge clk_in);
    ack_en = 1'b0;
    exp_gq.push_back(2'b01); exp_gq.push_back(2'b10);
    exp_q0.push_back({1'b1, 32'h0});
    exp_q1.push_back({1'b0, 32'hC0DE_0003});
    drive(0, 32'h0000_0004, 1'b0, 32'h0);
    @(negedge clk_in);
    chk("to_c1_err", {63'h0, m0_if.err}, 64'h0);
    drive(1, 32'h0000_000C, 1'b0, 32'h0);
    @(negedge clk_in);
    chk("to_c2_err", {63'h0, m0_if.err}, 64'h0);
    @(negedge clk_in);
    chk("to_c3_err", {63'h0, m0_if.err}, 64'h0);
    @(negedge clk_in);
    chk("to_c4_err", {63'h0, m0_if.err}, 64'h1);
    chk("to_c4_s_stb", {63'h0, s_if.stb}, 64'h0);
    ack_en = 1'b1;
    #1 release_m(0);
    @(negedge clk_in);
    chk("to_idle", {62'h0, grant_out}, 64'h0);
    @(negedge clk_in);
    chk("to_m1_grant", {62'h0, grant_out}, 64'h2);
    wait_term(1, 1'b0);
`endif

    repeat (3) @(negedge clk_in);
    chk("m0_queue_drained", 64'(exp_q0.size()), 64'h0);
    chk("m1_queue_drained", 64'(exp_q1.size()), 64'h0);
    chk("grant_queue_drained", 64'(exp_gq.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
